// File: rtl/cpm_topk_ser_pkg.sv
// Shared CPM definitions: serializer FSM encoding and default datapath widths.
package cpm_topk_ser_pkg;

  // Serializer FSM: IDLE waits for a frame, SEND streams the held entries.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } cpm_state_e;

  localparam int CPM_DATA_DW = 8;
  localparam int CPM_INFO_DW = 8;
  localparam int CPM_SORT_DW = 32;

endpackage

// File: rtl/cpm_topk_ser.sv
// Top-K serializer: on each rising edge of TOPK_DAT_VLD, snapshot the first
// TOPK_NUM sorted entries and stream them out one per handshake, largest first.
module cpm_topk_ser
  import cpm_topk_ser_pkg::*;
#(
  parameter int DATA_DW  = CPM_DATA_DW,
  parameter int INFO_DW  = CPM_INFO_DW,
  parameter int SORT_DW  = CPM_SORT_DW,
  parameter int TOPK_NUM = 8,
  parameter int SORT_AW  = $clog2(SORT_DW)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear,
  input  logic                       TOPK_DAT_VLD,
  input  logic [SORT_DW*DATA_DW-1:0] TOPK_DAT_DAT,
  input  logic [SORT_DW*INFO_DW-1:0] TOPK_DAT_INF,
  output logic                       OUT_DAT_VLD,
  input  logic                       OUT_DAT_RDY,
  output logic                       OUT_DAT_LST,
  output logic [DATA_DW-1:0]         OUT_DAT_DAT,
  output logic [INFO_DW-1:0]         OUT_DAT_INF,
  output logic [SORT_AW-1:0]         OUT_DAT_IDX,
  output logic                       BUSY,
  output logic                       OVF
);

  // Shadow depth is rounded up to the index range so cnt can address it
  // directly; entries at and above TOPK_NUM stay zero.
  localparam int                 SH_D     = 1 << SORT_AW;
  localparam logic [SORT_AW-1:0] LAST_IDX = SORT_AW'(TOPK_NUM - 1);

  cpm_state_e         state;
  logic               vld_d;
  logic [SORT_AW-1:0] cnt;
  logic               ovf_q;
  logic [DATA_DW-1:0] sh_dat [SH_D];
  logic [INFO_DW-1:0] sh_inf [SH_D];

  logic frame_start;
  logic hs;
  logic is_last;
  logic capture;

  assign frame_start = TOPK_DAT_VLD && !vld_d;
  assign hs          = (state == ST_SEND) && OUT_DAT_RDY;
  assign is_last     = (cnt == LAST_IDX);
  // A new frame is accepted when idle, or back-to-back on the final handshake.
  assign capture     = !clear && frame_start &&
                       ((state == ST_IDLE) || (hs && is_last));

  // Control path: edge detector, FSM, beat counter and sticky overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
      vld_d <= 1'b0;
      ovf_q <= 1'b0;
    end else if (clear) begin
      state <= ST_IDLE;
      cnt   <= '0;
      vld_d <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      vld_d <= TOPK_DAT_VLD;
      if (capture) begin
        state <= ST_SEND;
        cnt   <= '0;
      end else if (hs) begin
        if (is_last) begin
          state <= ST_IDLE;
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
      if (frame_start && !capture && (state == ST_SEND)) begin
        ovf_q <= 1'b1;
      end
    end
  end

  // Shadow snapshot of the emitted entries; a dropped frame leaves it untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SH_D; i++) begin
        sh_dat[i] <= '0;
        sh_inf[i] <= '0;
      end
    end else if (clear) begin
      for (int i = 0; i < SH_D; i++) begin
        sh_dat[i] <= '0;
        sh_inf[i] <= '0;
      end
    end else if (capture) begin
      for (int i = 0; i < TOPK_NUM; i++) begin
        sh_dat[i] <= TOPK_DAT_DAT[i*DATA_DW +: DATA_DW];
        sh_inf[i] <= TOPK_DAT_INF[i*INFO_DW +: INFO_DW];
      end
    end
  end

  // Entries beyond TOPK_NUM are never serialized.
  generate
    if (TOPK_NUM < SORT_DW) begin : g_unused
      logic unused_hi;
      assign unused_hi = ^{TOPK_DAT_DAT[SORT_DW*DATA_DW-1:TOPK_NUM*DATA_DW],
                           TOPK_DAT_INF[SORT_DW*INFO_DW-1:TOPK_NUM*INFO_DW]};
    end
  endgenerate

  assign OUT_DAT_VLD = (state == ST_SEND);
  assign OUT_DAT_LST = (state == ST_SEND) && is_last;
  assign OUT_DAT_DAT = sh_dat[cnt];
  assign OUT_DAT_INF = sh_inf[cnt];
  assign OUT_DAT_IDX = cnt;
  assign BUSY        = (state == ST_SEND);
  assign OVF         = ovf_q;

endmodule

// File: tb/tb_cpm_topk_ser.sv
// Bench for cpm_topk_ser: directed scenarios plus random traffic, checked
// against a queue-of-pending-beats reference model.
module tb_cpm_topk_ser;

  localparam int DW = 8;
  localparam int IW = 8;
  localparam int SD = 8;
  localparam int TK = 4;
  localparam int AW = $clog2(SD);

  logic              clk = 1'b0;
  logic              rst_n;
  logic              clear;
  logic              tvld;
  logic [SD*DW-1:0]  tdat;
  logic [SD*IW-1:0]  tinf;
  logic              rdy;
  logic              out_vld, lst, busy, ovf;
  logic [DW-1:0]     odat;
  logic [IW-1:0]     oinf;
  logic [AW-1:0]     oidx;
  logic              o1_vld, o1_lst, o1_busy, o1_ovf;
  logic [DW-1:0]     o1_dat;
  logic [IW-1:0]     o1_inf;
  logic [AW-1:0]     o1_idx;

  always #5 clk = ~clk;

  cpm_topk_ser #(.DATA_DW(DW), .INFO_DW(IW), .SORT_DW(SD), .TOPK_NUM(TK)) u_dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .TOPK_DAT_VLD(tvld),
    .TOPK_DAT_DAT(tdat), .TOPK_DAT_INF(tinf), .OUT_DAT_VLD(out_vld),
    .OUT_DAT_RDY(rdy), .OUT_DAT_LST(lst), .OUT_DAT_DAT(odat),
    .OUT_DAT_INF(oinf), .OUT_DAT_IDX(oidx), .BUSY(busy), .OVF(ovf)
  );

  cpm_topk_ser #(.DATA_DW(DW), .INFO_DW(IW), .SORT_DW(SD), .TOPK_NUM(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .TOPK_DAT_VLD(tvld),
    .TOPK_DAT_DAT(tdat), .TOPK_DAT_INF(tinf), .OUT_DAT_VLD(o1_vld),
    .OUT_DAT_RDY(rdy), .OUT_DAT_LST(o1_lst), .OUT_DAT_DAT(o1_dat),
    .OUT_DAT_INF(o1_inf), .OUT_DAT_IDX(o1_idx), .BUSY(o1_busy), .OVF(o1_ovf)
  );

  typedef struct packed {
    logic [DW-1:0] d;
    logic [IW-1:0] i;
    logic [AW-1:0] x;
    logic          l;
  } beat_t;

  beat_t q[$];
  bit    m_ovf;
  bit    m_prev;
  bit    m_zero;
  int    tests  = 0;
  int    fails  = 0;
  int    obs_hs = 0;

  logic [DW-1:0] fdat [SD];
  logic [IW-1:0] finf [SD];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load_frame();
    for (int k = 0; k < SD; k++) begin
      tdat[k*DW +: DW] = fdat[k];
      tinf[k*IW +: IW] = finf[k];
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ovf  = 1'b0;
    m_prev = 1'b0;
    m_zero = 1'b1;
  endtask

  // Compare DUT outputs with the model, advance the model with the inputs
  // the DUT samples at the coming edge, then move to 1 time unit past it.
  task automatic step();
    beat_t b;
    bit    hs, fs;
    chk("vld", out_vld, q.size() > 0);
    chk("busy", busy, q.size() > 0);
    chk("ovf", ovf, m_ovf);
    if (q.size() > 0) begin
      b = q[0];
      chk("dat", odat, b.d);
      chk("inf", oinf, b.i);
      chk("idx", oidx, b.x);
      chk("lst", lst, b.l);
    end else begin
      chk("lst_idle", lst, 0);
      if (m_zero) begin
        chk("dat_zero", odat, 0);
        chk("inf_zero", oinf, 0);
        chk("idx_zero", oidx, 0);
      end
    end
    if (out_vld && rdy && rst_n) obs_hs++;
    if (!rst_n || clear) begin
      model_reset();
    end else begin
      hs = (q.size() > 0) && rdy;
      fs = tvld && !m_prev;
      m_prev = tvld;
      if (hs) void'(q.pop_front());
      if (fs) begin
        if (q.size() == 0) begin
          for (int k = 0; k < TK; k++) begin
            b.d = tdat[k*DW +: DW];
            b.i = tinf[k*IW +: IW];
            b.x = AW'(k);
            b.l = (k == TK - 1);
            q.push_back(b);
          end
          m_zero = 1'b0;
        end else begin
          m_ovf = 1'b1;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; clear = 1'b0; tvld = 1'b0; rdy = 1'b0;
    tdat = '0; tinf = '0;
    model_reset();
    repeat (3) step();
    rst_n = 1'b1;
    repeat (2) step();

    // Basic frame with RDY high; TOPK_VLD held high for 10 cycles.
    for (int k = 0; k < SD; k++) begin
      fdat[k] = DW'($urandom_range(0, 29));
      finf[k] = IW'(k + 1);
    end
    fdat[0] = 8'd90; fdat[1] = 8'd70; fdat[2] = 8'd50; fdat[3] = 8'd30;
    load_frame();
    rdy = 1'b1; tvld = 1'b1;
    step();
    chk("s1_first_vld", out_vld, 1);
    chk("s1_first_dat", odat, 90);
    chk("s1_first_inf", oinf, 1);
    chk("k1_vld", o1_vld, 1);
    chk("k1_lst", o1_lst, 1);
    chk("k1_dat", o1_dat, 90);
    chk("k1_idx", o1_idx, 0);
    step();
    chk("s1_beat2_dat", odat, 70);
    chk("s1_beat2_idx", oidx, 1);
    chk("k1_done", o1_vld, 0);
    repeat (8) step();
    tvld = 1'b0;
    repeat (3) step();

    // Same frame with RDY toggling 1,0,0,1.
    obs_hs = 0;
    step();
    tvld = 1'b1;
    for (int c = 0; c < 16; c++) begin
      rdy = (c % 4 == 0) || (c % 4 == 3);
      step();
    end
    chk("s2_handshakes", obs_hs, 4);
    tvld = 1'b0; rdy = 1'b1;
    step();

    // Second edge two cycles into a stalled frame is dropped.
    tvld = 1'b1; rdy = 1'b0;
    step();
    tvld = 1'b0;
    step();
    tvld = 1'b1;
    fdat[0] = 8'd11; fdat[1] = 8'd12; fdat[2] = 8'd13; fdat[3] = 8'd14;
    load_frame();
    step();
    chk("s3_ovf_set", ovf, 1);
    chk("s3_orig_dat", odat, 90);
    rdy = 1'b1;
    repeat (6) step();
    chk("s3_ovf_sticky", ovf, 1);
    clear = 1'b1; tvld = 1'b0;
    step();
    clear = 1'b0;
    chk("s3_ovf_clr", ovf, 0);
    chk("s3_clr_dat", odat, 0);
    step();

    // New edge on the same cycle as the LST handshake.
    fdat[0] = 8'd90; fdat[1] = 8'd70; fdat[2] = 8'd50; fdat[3] = 8'd30;
    load_frame();
    tvld = 1'b1; rdy = 1'b1;
    step();
    step();
    step();
    tvld = 1'b0;
    step();
    chk("s4_lst_pending", lst, 1);
    tvld = 1'b1;
    fdat[0] = 8'd200; fdat[1] = 8'd150; fdat[2] = 8'd100; fdat[3] = 8'd60;
    load_frame();
    step();
    chk("s4_b2b_vld", out_vld, 1);
    chk("s4_b2b_idx", oidx, 0);
    chk("s4_b2b_dat", odat, 200);
    chk("s4_b2b_ovf", ovf, 0);
    repeat (5) step();
    tvld = 1'b0;
    step();

    // Reset pulse at beat 2 abandons the frame.
    tvld = 1'b1;
    step();
    step();
    chk("s5_beat2_idx", oidx, 1);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("s5_rst_vld", out_vld, 0);
    chk("s5_rst_lst", lst, 0);
    chk("s5_rst_dat", odat, 0);
    chk("s5_rst_inf", oinf, 0);
    chk("s5_rst_idx", oidx, 0);
    chk("s5_rst_busy", busy, 0);
    repeat (2) step();
    rst_n = 1'b1;
    obs_hs = 0;
    repeat (7) step();
    chk("s5_full_frame", obs_hs, TK);
    tvld = 1'b0;
    step();

    // Random traffic.
    for (int c = 0; c < 500; c++) begin
      if ($urandom_range(0, 2) == 0) tvld = !tvld;
      rdy   = ($urandom_range(0, 3) != 0);
      clear = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 3) == 0) begin
        for (int k = 0; k < SD; k++) begin
          fdat[k] = DW'($urandom);
          finf[k] = IW'($urandom);
        end
        load_frame();
      end
      step();
    end
    clear = 1'b0; tvld = 1'b0; rdy = 1'b1;
    repeat (6) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
